// File: rtl/timing_attack_driver.sv
// timing_attack_driver: plays 4-press guess sequences onto a key checker's button lines and
// recovers the 8-bit key digit by digit from how long each fail response takes.
module timing_attack_driver #(
    parameter int unsigned PRESS_CYCLES   = 100_000,
    parameter int unsigned RELEASE_CYCLES = 100_000,
    parameter int unsigned GAP_CYCLES     = 1_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned LAT_W          = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             success_in,
    input  logic             fail_in,
    output logic [2:0]       btn_out,
    output logic             chk_restart,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             timeout,
    output logic [7:0]       key_out,
    output logic [4:0]       guess_count,
    output logic [LAT_W-1:0] last_latency
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS   = 3'd1,
        S_RELEASE = 3'd2,
        S_MEASURE = 3'd3,
        S_GAP     = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [31:0]      PRESS_LAST   = 32'(PRESS_CYCLES - 1);
    localparam logic [31:0]      RELEASE_LAST = 32'(RELEASE_CYCLES - 1);
    localparam logic [31:0]      GAP_LAST     = 32'(GAP_CYCLES - 1);
    localparam logic [LAT_W-1:0] TIMEOUT_LAST = LAT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_MAX      = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] LAT_ZERO     = {LAT_W{1'b0}};

    function automatic logic [2:0] sym_to_btn(input logic [1:0] sym);
        logic [2:0] btn;
        case (sym)
            2'd0:    btn = 3'b001;
            2'd1:    btn = 3'b010;
            2'd2:    btn = 3'b100;
            2'd3:    btn = 3'b110;
            default: btn = 3'b000;
        endcase
        return btn;
    endfunction

    // Slots before pos replay the recovered digits, slot pos carries the candidate, the rest are 0.
    function automatic logic [1:0] guess_sym(input logic [7:0] digits, input logic [1:0] pos,
                                             input logic [1:0] cand, input logic [1:0] slot);
        logic [1:0] sym;
        if (slot < pos) begin
            sym = digits[{slot, 1'b0} +: 2];
        end else if (slot == pos) begin
            sym = cand;
        end else begin
            sym = 2'd0;
        end
        return sym;
    endfunction

    function automatic logic [7:0] build_guess(input logic [7:0] digits, input logic [1:0] pos,
                                               input logic [1:0] cand);
        logic [7:0] g;
        g = 8'h00;
        for (int i = 0; i < 4; i++) begin
            g[2*i +: 2] = guess_sym(digits, pos, cand, 2'(i));
        end
        return g;
    endfunction

    function automatic logic [7:0] set_digit(input logic [7:0] digits, input logic [1:0] pos,
                                             input logic [1:0] val);
        logic [7:0] d;
        d = digits;
        d[{pos, 1'b0} +: 2] = val;
        return d;
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       pos_q, pos_d;
    logic [1:0]       cand_q, cand_d;
    logic [LAT_W-1:0] best_lat_q, best_lat_d;
    logic [1:0]       best_cand_q, best_cand_d;
    logic [7:0]       digits_q, digits_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [2:0]       btn_out_q, btn_out_d;
    logic             chk_restart_q, chk_restart_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       key_out_q, key_out_d;
    logic [4:0]       guess_count_q, guess_count_d;
    logic [LAT_W-1:0] last_latency_q, last_latency_d;

    logic             start_attack_s;
    logic [7:0]       guess_s;
    logic [LAT_W-1:0] sel_lat_s;
    logic [1:0]       sel_cand_s;
    logic [7:0]       new_digits_s;

    // Best-candidate bookkeeping for the current response; strict > keeps the lower candidate on ties.
    always_comb begin
        guess_s = build_guess(digits_q, pos_q, cand_q);
        if (lat_q > best_lat_q) begin
            sel_lat_s  = lat_q;
            sel_cand_s = cand_q;
        end else begin
            sel_lat_s  = best_lat_q;
            sel_cand_s = best_cand_q;
        end
        new_digits_s = set_digit(digits_q, pos_q, sel_cand_s);
    end

    // Next-state and next-output logic of the attack sequencer.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        pos_d          = pos_q;
        cand_d         = cand_q;
        best_lat_d     = best_lat_q;
        best_cand_d    = best_cand_q;
        digits_d       = digits_q;
        lat_d          = lat_q;
        chk_restart_d  = 1'b0;
        found_d        = found_q;
        timeout_d      = timeout_q;
        key_out_d      = key_out_q;
        guess_count_d  = guess_count_q;
        last_latency_d = last_latency_q;
        start_attack_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_attack_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRESS: begin
                if (cnt_q == PRESS_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == RELEASE_LAST) begin
                    cnt_d = 32'd0;
                    if (idx_q == 2'd3) begin
                        state_d = S_MEASURE;
                        lat_d   = LAT_ZERO;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_PRESS;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_MEASURE: begin
                if (success_in || fail_in) begin
                    last_latency_d = lat_q;
                    guess_count_d  = guess_count_q + 5'd1;
                    if (success_in) begin
                        key_out_d = guess_s;
                        found_d   = 1'b1;
                        state_d   = S_DONE;
                    end else if (cand_q != 2'd3) begin
                        cand_d      = cand_q + 2'd1;
                        best_lat_d  = sel_lat_s;
                        best_cand_d = sel_cand_s;
                        cnt_d       = 32'd0;
                        state_d     = S_GAP;
                    end else begin
                        // Last candidate for this digit: commit the slowest-failing one.
                        digits_d    = new_digits_s;
                        cand_d      = 2'd0;
                        best_lat_d  = LAT_ZERO;
                        best_cand_d = 2'd0;
                        if (pos_q == 2'd3) begin
                            key_out_d = new_digits_s;
                            found_d   = 1'b0;
                            state_d   = S_DONE;
                        end else begin
                            pos_d   = pos_q + 2'd1;
                            cnt_d   = 32'd0;
                            state_d = S_GAP;
                        end
                    end
                end else if (lat_q >= TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else if (lat_q != LAT_MAX) begin
                    lat_d = lat_q + LAT_W'(1);
                end else begin
                    lat_d = lat_q;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    idx_d   = 2'd0;
                    cnt_d   = 32'd0;
                    state_d = S_PRESS;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    start_attack_s = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_attack_s) begin
            chk_restart_d  = 1'b1;
            state_d        = S_PRESS;
            cnt_d          = 32'd0;
            idx_d          = 2'd0;
            pos_d          = 2'd0;
            cand_d         = 2'd0;
            best_lat_d     = LAT_ZERO;
            best_cand_d    = 2'd0;
            digits_d       = 8'h00;
            lat_d          = LAT_ZERO;
            found_d        = 1'b0;
            timeout_d      = 1'b0;
            key_out_d      = 8'h00;
            guess_count_d  = 5'd0;
            last_latency_d = LAT_ZERO;
        end else begin
            chk_restart_d = 1'b0;
        end

        // Button and status outputs follow the state being entered so they line up with it.
        if (state_d == S_PRESS) begin
            btn_out_d = sym_to_btn(guess_sym(digits_d, pos_d, cand_d, idx_d));
        end else begin
            btn_out_d = 3'b000;
        end
        busy_d = (state_d == S_PRESS) || (state_d == S_RELEASE) ||
                 (state_d == S_MEASURE) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 32'd0;
            idx_q          <= 2'd0;
            pos_q          <= 2'd0;
            cand_q         <= 2'd0;
            best_lat_q     <= LAT_ZERO;
            best_cand_q    <= 2'd0;
            digits_q       <= 8'h00;
            lat_q          <= LAT_ZERO;
            btn_out_q      <= 3'b000;
            chk_restart_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            found_q        <= 1'b0;
            timeout_q      <= 1'b0;
            key_out_q      <= 8'h00;
            guess_count_q  <= 5'd0;
            last_latency_q <= LAT_ZERO;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pos_q          <= pos_d;
            cand_q         <= cand_d;
            best_lat_q     <= best_lat_d;
            best_cand_q    <= best_cand_d;
            digits_q       <= digits_d;
            lat_q          <= lat_d;
            btn_out_q      <= btn_out_d;
            chk_restart_q  <= chk_restart_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            found_q        <= found_d;
            timeout_q      <= timeout_d;
            key_out_q      <= key_out_d;
            guess_count_q  <= guess_count_d;
            last_latency_q <= last_latency_d;
        end
    end

    assign btn_out      = btn_out_q;
    assign chk_restart  = chk_restart_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign found        = found_q;
    assign timeout      = timeout_q;
    assign key_out      = key_out_q;
    assign guess_count  = guess_count_q;
    assign last_latency = last_latency_q;

endmodule

// File: tb/tb_timing_attack_driver.sv
// Bench for timing_attack_driver: a behavioural key-checker answers each guess with a
// latency that leaks leading matches; whole attacks are compared with an algorithmic model.
module tb_timing_attack_driver;

    localparam int PC = 8;
    localparam int RC = 8;
    localparam int GC = 5;
    localparam int TO = 300;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          success_in;
    logic          fail_in;
    logic [2:0]    btn_out;
    logic          chk_restart;
    logic          busy;
    logic          done;
    logic          found;
    logic          timeout;
    logic [7:0]    key_out;
    logic [4:0]    guess_count;
    logic [LW-1:0] last_latency;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          model_mode = 0;   // 0 normal, 1 equal latency/no success, 2 silent, 3 both high
    logic [7:0]  model_key = 8'h00;

    always #5 clk = ~clk;

    timing_attack_driver #(
        .PRESS_CYCLES(PC), .RELEASE_CYCLES(RC), .GAP_CYCLES(GC),
        .TIMEOUT_CYCLES(TO), .LAT_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .success_in(success_in), .fail_in(fail_in),
        .btn_out(btn_out), .chk_restart(chk_restart), .busy(busy), .done(done),
        .found(found), .timeout(timeout), .key_out(key_out), .guess_count(guess_count),
        .last_latency(last_latency)
    );

    function automatic int btn_to_sym(input logic [2:0] b);
        case (b)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            3'b110:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int key_digit(input logic [7:0] key, input int i);
        logic [7:0] t;
        t = (key >> (2 * i)) & 8'h03;
        return int'(t);
    endfunction

    function automatic int leading(input int g[4], input logic [7:0] key);
        int m;
        m = 0;
        for (int i = 0; i < 4; i++)
            if (m == i && g[i] == key_digit(key, i)) m++;
        return m;
    endfunction

    // Attack outcome from the algorithm itself: sweep candidates, keep the strictly slowest.
    function automatic void ref_attack(input int mode, input logic [7:0] key, output bit f,
                                       output logic [7:0] k, output int cnt, output int lat);
        int digits[4];
        int g[4];
        int best_l, best_c, m, l;
        digits = '{0, 0, 0, 0};
        f = 1'b0; k = 8'h00; cnt = 0; lat = 0;
        for (int p = 0; p < 4; p++) begin
            best_l = 0; best_c = 0;
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 4; i++) g[i] = (i < p) ? digits[i] : ((i == p) ? c : 0);
                cnt++;
                m = leading(g, key);
                l = (mode == 1) ? 40 : 10 + 20 * m;
                lat = l;
                if ((mode == 0 && m == 4) || mode == 3) begin
                    f = 1'b1;
                    for (int i = 0; i < 4; i++) k = k | (8'(g[i]) << (2 * i));
                    return;
                end
                if (l > best_l) begin best_l = l; best_c = c; end
            end
            digits[p] = best_c;
        end
        for (int i = 0; i < 4; i++) k = k | (8'(digits[i]) << (2 * i));
    endfunction

    // Behavioural checker: collects four presses, answers RC+lat cycles after the last press ends.
    initial begin : checker_model
        int nprs;
        bit in_press;
        int cd;
        int syms[4];
        int m;
        int lat;
        nprs = 0; in_press = 1'b0; cd = -1; m = 0;
        success_in = 1'b0; fail_in = 1'b0;
        forever begin
            @(negedge clk);
            success_in = 1'b0;
            fail_in = 1'b0;
            if (rst) begin
                nprs = 0; in_press = 1'b0; cd = -1;
            end else begin
                if (chk_restart) begin nprs = 0; in_press = 1'b0; cd = -1; end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        if (model_mode == 3) begin success_in = 1'b1; fail_in = 1'b1; end
                        else if (model_mode == 0 && m == 4) success_in = 1'b1;
                        else fail_in = 1'b1;
                        cd = -1;
                        nprs = 0;
                    end
                end
                if (btn_out !== 3'b000 && !in_press) begin
                    in_press = 1'b1;
                    if (nprs < 4) syms[nprs] = btn_to_sym(btn_out);
                    nprs++;
                end else if (btn_out === 3'b000 && in_press) begin
                    in_press = 1'b0;
                    if (nprs == 4 && model_mode != 2) begin
                        m = leading(syms, model_key);
                        lat = (model_mode == 1) ? 40 : 10 + 20 * m;
                        cd = RC + lat;
                    end
                end
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int restarts);
        n = 0; restarts = 0;
        while (done !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
            if (chk_restart === 1'b1) restarts++;
        end
    endtask

    task automatic run_attack(input string name, input int mode, input logic [7:0] key);
        bit ef; logic [7:0] ek; int ec, el, n, rs;
        model_mode = mode;
        model_key = key;
        ref_attack(mode, key, ef, ek, ec, el);
        do_start();
        wait_done(n, rs);
        tests_run++;
        if (done !== 1'b1) begin tests_failed++; $display("FAIL %s done: got %b want 1 (waited %0d cycles)", name, done, n); end
        tests_run++;
        if (found !== ef) begin tests_failed++; $display("FAIL %s found: got %b want %b", name, found, ef); end
        tests_run++;
        if (key_out !== ek) begin tests_failed++; $display("FAIL %s key_out: got %h want %h", name, key_out, ek); end
        tests_run++;
        if (guess_count !== 5'(ec)) begin tests_failed++; $display("FAIL %s guess_count: got %0d want %0d", name, guess_count, ec); end
        tests_run++;
        if (last_latency !== LW'(el)) begin tests_failed++; $display("FAIL %s last_latency: got %0d want %0d", name, last_latency, el); end
        tests_run++;
        if ({busy, timeout, btn_out} !== 5'b00000) begin tests_failed++; $display("FAIL %s idle outputs: got busy=%b timeout=%b btn=%b want 0", name, busy, timeout, btn_out); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({btn_out, chk_restart, busy, done, found, timeout} !== 8'h00) begin
            tests_failed++; $display("FAIL reset flags: got btn=%b rs=%b busy=%b done=%b found=%b to=%b want 0",
                                     btn_out, chk_restart, busy, done, found, timeout);
        end
        tests_run++;
        if ({key_out, guess_count, last_latency} !== 25'd0) begin
            tests_failed++; $display("FAIL reset data: got key=%h cnt=%0d lat=%0d want 0", key_out, guess_count, last_latency);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_known_key();
        run_attack("key_b4", 0, 8'hB4);
        tests_run++;
        if (guess_count > 5'd16) begin tests_failed++; $display("FAIL key_b4 bound: got %0d want <=16", guess_count); end
    endtask

    task automatic test_zero_key();
        run_attack("key_00", 0, 8'h00);
    endtask

    task automatic test_random_keys();
        for (int i = 0; i < 4; i++) run_attack("rand_key", 0, 8'($urandom));
    endtask

    task automatic test_equal_latency();
        run_attack("equal_lat", 1, 8'($urandom));
    endtask

    task automatic test_both_high();
        run_attack("both_high", 3, 8'($urandom_range(255, 1)));
    endtask

    task automatic test_timeout();
        int n;
        model_mode = 2;
        model_key = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (done === 1'b1) break;
        end
        tests_run++;
        if (n !== 4 * (PC + RC) + TO + 1) begin tests_failed++; $display("FAIL timeout cycles: got %0d want %0d", n, 4 * (PC + RC) + TO + 1); end
        tests_run++;
        if ({timeout, found, btn_out, busy} !== 6'b100000) begin
            tests_failed++; $display("FAIL timeout flags: got to=%b found=%b btn=%b busy=%b want 1,0,000,0", timeout, found, btn_out, busy);
        end
        tests_run++;
        if (guess_count !== 5'd0) begin tests_failed++; $display("FAIL timeout count: got %0d want 0", guess_count); end
    endtask

    task automatic test_reset_mid_press();
        int n;
        model_mode = 0;
        model_key = 8'hFF;
        do_start();
        n = 0;
        while (btn_out !== 3'b010 && n < 3000) begin @(negedge clk); n++; end
        tests_run++;
        if (btn_out !== 3'b010 || guess_count !== 5'd1) begin
            tests_failed++; $display("FAIL midpress setup: got btn=%b cnt=%0d want 010 and 1", btn_out, guess_count);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({btn_out, busy, guess_count, done} !== 10'd0) begin
            tests_failed++; $display("FAIL midpress reset: got btn=%b busy=%b cnt=%0d done=%b want 0", btn_out, busy, guess_count, done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ef; logic [7:0] ek; int ec, el, n, rs;
        run_attack("b2b_first", 0, 8'h27);
        model_key = 8'($urandom);
        ref_attack(0, model_key, ef, ek, ec, el);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({chk_restart, busy, done} !== 3'b110) begin
            tests_failed++; $display("FAIL b2b restart: got rs=%b busy=%b done=%b want 1,1,0", chk_restart, busy, done);
        end
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, rs);
        tests_run++;
        if (rs !== 0) begin tests_failed++; $display("FAIL b2b busy_start: got %0d restarts want 0", rs); end
        tests_run++;
        if ({found, key_out, guess_count} !== {ef, ek, 5'(ec)}) begin
            tests_failed++; $display("FAIL b2b second: got found=%b key=%h cnt=%0d want %b %h %0d", found, key_out, guess_count, ef, ek, ec);
        end
    endtask

    initial begin
        test_reset();
        test_known_key();
        test_zero_key();
        test_random_keys();
        test_equal_latency();
        test_both_high();
        test_timeout();
        test_reset_mid_press();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
